// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 matrix keypad scanner and its consumers.
// FSM encodings are plain constants so older blocks can share them unchanged.
package keypad_pkg;

    localparam int NROWS = 4;
    localparam int NCOLS = 4;

    localparam logic [1:0] SCAN    = 2'd0;
    localparam logic [1:0] PDEB    = 2'd1;
    localparam logic [1:0] PRESSED = 2'd2;
    localparam logic [1:0] RDEB    = 2'd3;

    // ASCII legend printed on the keycap for a given row*4+col code.
    function automatic logic [7:0] key_legend(input logic [3:0] code);
        logic [7:0] ch;
        case (code)
            4'd0:    ch = "1";
            4'd1:    ch = "2";
            4'd2:    ch = "3";
            4'd3:    ch = "A";
            4'd4:    ch = "4";
            4'd5:    ch = "5";
            4'd6:    ch = "6";
            4'd7:    ch = "B";
            4'd8:    ch = "7";
            4'd9:    ch = "8";
            4'd10:   ch = "9";
            4'd11:   ch = "C";
            4'd12:   ch = "*";
            4'd13:   ch = "0";
            4'd14:   ch = "#";
            default: ch = "D";
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running modulo-N counter producing a one-cycle tick when the count is N-1.
module keypad_tick_gen #(
    parameter int N = 8192
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row strobing, press/release debounce on scan ticks,
// and a one-entry key-code buffer with acknowledge and sticky overrun.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_TO_SCANFREQ = 8192,
    parameter int DEBOUNCE_SCANS  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCOLS-1:0] cols_n,
    input  logic             key_ack,
    output logic [NROWS-1:0] rows_n,
    output logic [3:0]       key_code,
    output logic             key_valid,
    output logic             key_held,
    output logic             overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    logic             tick;
    logic [NCOLS-1:0] cols_m_q, cols_s_q;
    logic [1:0]       state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NROWS-1:0] rows_n_q, rows_n_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic             overrun_q, overrun_d;
    logic [1:0]       low_col;
    logic             any_low, col_low, accept, ack;

    keypad_tick_gen #(.N(CLK_TO_SCANFREQ)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Lowest-index pressed column wins when several columns read low.
    always_comb begin
        low_col = '0;
        for (int i = NCOLS - 1; i >= 0; i--) begin
            if (!cols_s_q[i]) low_col = 2'(i);
        end
    end

    assign any_low = ~&cols_s_q;
    assign col_low = ~cols_s_q[col_q];

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        key_held_d = key_held_q;
        accept     = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        col_d   = low_col;
                        cnt_d   = CNT_W'(1);
                        state_d = PDEB;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
                PDEB: begin
                    if (col_low) begin
                        if (cnt_q >= CNT_LAST) begin
                            accept     = 1'b1;
                            key_held_d = 1'b1;
                            state_d    = PRESSED;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        row_d   = row_q + 2'd1;
                        state_d = SCAN;
                    end
                end
                PRESSED: begin
                    if (!col_low) begin
                        cnt_d   = CNT_W'(1);
                        state_d = RDEB;
                    end
                end
                RDEB: begin
                    if (!col_low) begin
                        if (cnt_q >= CNT_LAST) begin
                            key_held_d = 1'b0;
                            row_d      = row_q + 2'd1;
                            state_d    = SCAN;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = PRESSED;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // An accept coinciding with an ack replaces the buffered code instead of overrunning.
    assign ack = key_ack & key_valid_q;

    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (accept) begin
            if (!key_valid_q || key_ack) begin
                key_code_d  = {row_q, col_q};
                key_valid_d = 1'b1;
                overrun_d   = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (ack) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
        rows_n_d = ~(4'b0001 << row_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cols_m_q    <= '1;
            cols_s_q    <= '1;
            state_q     <= SCAN;
            row_q       <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            rows_n_q    <= '1;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cols_m_q    <= cols_n;
            cols_s_q    <= cols_m_q;
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            rows_n_q    <= rows_n_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rows_n    = rows_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a single-key matrix model; ticks are counted
// from reset release so every expected value below is tied to a known tick number.
module tb_keypad_scanner;

    localparam int N = 16;
    localparam int D = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cols_n;
    logic       key_ack = 1'b0;
    logic [3:0] rows_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       overrun;

    logic       key_down = 1'b0;
    logic [1:0] key_row = 2'd0;
    logic [1:0] key_col = 2'd0;

    int   total = 0;
    int   bad = 0;
    int   rises = 0;
    int   phase = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .CLK_TO_SCANFREQ (N),
        .DEBOUNCE_SCANS  (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cols_n    (cols_n),
        .key_ack   (key_ack),
        .rows_n    (rows_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    // The held key pulls its column low only while its row is strobed.
    always_comb begin
        cols_n = 4'hF;
        if (key_down && (rows_n[key_row] == 1'b0)) cols_n[key_col] = 1'b0;
    end

    // Reference scan phase: a tick edge is the posedge taken while phase == N-1.
    always @(posedge clk) begin
        if (!rst_n) phase <= 0;
        else        phase <= (phase == N - 1) ? 0 : phase + 1;
    end

    always @(negedge clk) begin
        if (key_valid && !prev_valid) rises = rises + 1;
        prev_valid = key_valid;
    end

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic down, input logic [1:0] r, input logic [1:0] c);
        key_down = down;
        key_row  = r;
        key_col  = c;
    endtask

    task automatic nextTick();
        while (phase != N - 1) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic nextTicks(input int n);
        for (int i = 0; i < n; i++) nextTick();
    endtask

    task automatic ackPulse();
        key_ack = 1'b1;
        @(posedge clk);
        #1;
        key_ack = 1'b0;
    endtask

    task automatic ackOnTick();
        while (phase != N - 1) @(negedge clk);
        key_ack = 1'b1;
        @(posedge clk);
        #1;
        key_ack = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rows", 8'(rows_n), 8'hF);
        checkOutput("reset_valid", 8'(key_valid), 8'h0);
        checkOutput("reset_code", 8'(key_code), 8'h0);
        checkOutput("reset_held", 8'(key_held), 8'h0);
        checkOutput("reset_overrun", 8'(overrun), 8'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_row0", 8'(rows_n), 8'hE);

        // Idle scanning, ticks 1..4
        nextTick();
        checkOutput("idle_row1", 8'(rows_n), 8'hD);
        nextTick();
        checkOutput("idle_row2", 8'(rows_n), 8'hB);
        nextTick();
        checkOutput("idle_row3", 8'(rows_n), 8'h7);
        nextTick();
        checkOutput("idle_wrap", 8'(rows_n), 8'hE);
        checkOutput("idle_valid", 8'(key_valid), 8'h0);

        // Clean press of key 9: detect at tick 7, accept at tick 9
        applyStimulus(1'b1, 2'd2, 2'd1);
        nextTicks(3);
        checkOutput("k9_row_held", 8'(rows_n), 8'hB);
        checkOutput("k9_detect_valid", 8'(key_valid), 8'h0);
        nextTick();
        checkOutput("k9_deb2_valid", 8'(key_valid), 8'h0);
        nextTick();
        checkOutput("k9_valid", 8'(key_valid), 8'h1);
        checkOutput("k9_code", 8'(key_code), 8'h9);
        checkOutput("k9_held", 8'(key_held), 8'h1);
        nextTicks(5);
        checkOutput("k9_code_stable", 8'(key_code), 8'h9);
        checkOutput("k9_once", 8'(rises), 8'd1);
        applyStimulus(1'b0, 2'd2, 2'd1);
        nextTicks(2);
        checkOutput("k9_held_rdeb", 8'(key_held), 8'h1);
        nextTick();
        checkOutput("k9_released", 8'(key_held), 8'h0);
        checkOutput("k9_resume_row3", 8'(rows_n), 8'h7);
        checkOutput("k9_valid_kept", 8'(key_valid), 8'h1);
        ackPulse();
        checkOutput("k9_ack_valid", 8'(key_valid), 8'h0);
        checkOutput("k9_ack_overrun", 8'(overrun), 8'h0);

        // Bounces on key 3: one-tick press, then two-tick press, then a real press
        applyStimulus(1'b1, 2'd0, 2'd3);
        nextTicks(2);
        applyStimulus(1'b0, 2'd0, 2'd3);
        nextTick();
        applyStimulus(1'b1, 2'd0, 2'd3);
        nextTicks(5);
        applyStimulus(1'b0, 2'd0, 2'd3);
        nextTick();
        checkOutput("bounce_valid", 8'(key_valid), 8'h0);
        checkOutput("bounce_rises", 8'(rises), 8'd1);
        checkOutput("bounce_row1", 8'(rows_n), 8'hD);
        applyStimulus(1'b1, 2'd0, 2'd3);
        nextTicks(5);
        checkOutput("k3_pre_valid", 8'(key_valid), 8'h0);
        nextTick();
        checkOutput("k3_valid", 8'(key_valid), 8'h1);
        checkOutput("k3_code", 8'(key_code), 8'h3);
        ackPulse();
        applyStimulus(1'b0, 2'd0, 2'd3);
        nextTicks(3);
        checkOutput("k3_released", 8'(key_held), 8'h0);
        checkOutput("k3_resume_row1", 8'(rows_n), 8'hD);

        // Handshake: key 5 left unacknowledged, key 12 overruns
        applyStimulus(1'b1, 2'd1, 2'd1);
        nextTicks(3);
        checkOutput("k5_code", 8'(key_code), 8'h5);
        applyStimulus(1'b0, 2'd1, 2'd1);
        nextTicks(3);
        checkOutput("k5_resume_row2", 8'(rows_n), 8'hB);
        applyStimulus(1'b1, 2'd3, 2'd0);
        nextTicks(4);
        checkOutput("k12_code_kept", 8'(key_code), 8'h5);
        checkOutput("k12_valid", 8'(key_valid), 8'h1);
        checkOutput("k12_overrun", 8'(overrun), 8'h1);
        checkOutput("k12_held", 8'(key_held), 8'h1);
        ackPulse();
        checkOutput("ovr_ack_valid", 8'(key_valid), 8'h0);
        checkOutput("ovr_ack_overrun", 8'(overrun), 8'h0);
        applyStimulus(1'b0, 2'd3, 2'd0);
        nextTicks(3);
        checkOutput("k12_resume_row0", 8'(rows_n), 8'hE);

        // Same-cycle ack and accept: key 5 buffered, ack lands on key 7's accept tick
        applyStimulus(1'b1, 2'd1, 2'd1);
        nextTicks(4);
        checkOutput("k5b_code", 8'(key_code), 8'h5);
        applyStimulus(1'b0, 2'd1, 2'd1);
        nextTicks(3);
        applyStimulus(1'b1, 2'd1, 2'd3);
        nextTicks(5);
        checkOutput("k7_pre_code", 8'(key_code), 8'h5);
        ackOnTick();
        checkOutput("k7_valid", 8'(key_valid), 8'h1);
        checkOutput("k7_code", 8'(key_code), 8'h7);
        checkOutput("k7_overrun", 8'(overrun), 8'h0);
        checkOutput("k7_rises", 8'(rises), 8'd4);
        applyStimulus(1'b0, 2'd1, 2'd3);
        nextTicks(3);
        ackPulse();
        checkOutput("k7_ack_valid", 8'(key_valid), 8'h0);

        // Reset while key 8 is in PRESSED
        applyStimulus(1'b1, 2'd2, 2'd0);
        nextTicks(3);
        checkOutput("k8_code", 8'(key_code), 8'h8);
        checkOutput("k8_held", 8'(key_held), 8'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_rows", 8'(rows_n), 8'hF);
        checkOutput("midrst_valid", 8'(key_valid), 8'h0);
        checkOutput("midrst_code", 8'(key_code), 8'h0);
        checkOutput("midrst_held", 8'(key_held), 8'h0);
        checkOutput("midrst_overrun", 8'(overrun), 8'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_row0", 8'(rows_n), 8'hE);
        applyStimulus(1'b0, 2'd2, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
